// File: rtl/addsub_arbiter.sv
// Two-requester front end for a shared WIDTH-bit ripple adder-subtractor.
// Requests are arbitrated round-robin and the granted operation is computed
// and captured in a single result register. That register carries the ID of
// the requester that issued it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | result register empty, out_valid=0
// FULL  | result register holds a result, out_valid=1
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_id
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]       state;
  logic             last_grant;
  logic             can_accept;
  logic             gnt_any;
  logic             gnt_id;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign out_valid = (state == FULL);

  // The register can take new data when it is empty or is being drained this cycle.
  // The reset cycle accepts nothing, so no ready is raised while rst is high.
  assign can_accept = !out_valid || out_ready;
  assign gnt_any    = req0_valid || req1_valid;
  assign accept     = !rst && can_accept && gnt_any;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  // Round-robin pick. Under contention the requester not served last wins.
  // Otherwise the only valid requester wins.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = !last_grant;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  // Operand steering from the granted requester into the shared datapath.
  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_sel = req0_sel;
    if (gnt_id) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_sel = req1_sel;
    end
  end

  // Ripple-carry adder computing A + (B ^ sel) + sel.
  // The final carry is the add carry-out, or the no-borrow flag for a subtract.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = op_sel;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = op_a[i] ^ (op_b[i] ^ op_sel) ^ carry[i];
      carry[i+1] = (op_a[i] & (op_b[i] ^ op_sel)) |
                   (carry[i] & (op_a[i] ^ (op_b[i] ^ op_sel)));
    end
  end

  // Result register and arbitration history.
  // Without an accept or a drain, the held result is left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      out_res    <= '0;
      out_cout   <= 1'b0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      out_res    <= sum;
      out_cout   <= carry[WIDTH];
      out_id     <= gnt_id;
      last_grant <= gnt_id;
    end else if (out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (WIDTH=4).
// Inputs are changed and outputs sampled 1 time unit after each rising edge.
module tb_addsub_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sel;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sel;
  logic [3:0] req1_a, req1_b;
  logic       out_valid, out_ready, out_cout, out_id;
  logic [3:0] out_res;

  int n_tests;
  int n_fail;

  addsub_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_cout   (out_cout),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on a single requester, with out_ready held high.
  task automatic single_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic sel, input logic [3:0] er, input logic ec);
    if (!id) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
    #1;
    chk("op_ready", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("op_valid", out_valid, 1);
    chk("op_res", out_res, er);
    chk("op_cout", out_cout, ec);
    chk("op_id", out_id, id);
    chk("op_no_ready", {req1_ready, req0_ready}, 0);
  endtask

  initial begin
    int r;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", out_res, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_id", out_id, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);

    // Directed arithmetic vectors.
    out_ready = 1'b1;
    single_op(1'b0, 4'd5, 4'd3, 1'b0, 4'd8,    1'b0);
    single_op(1'b1, 4'd3, 4'd5, 1'b1, 4'b1110, 1'b0);
    single_op(1'b1, 4'd9, 4'd4, 1'b1, 4'd5,    1'b1);
    single_op(1'b0, 4'd9, 4'd9, 1'b0, 4'd2,    1'b1);

    // Contention from a fresh reset: req0 gives 1+1=2, req1 gives 7-2=5.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_sel = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd2; req1_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready", {req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_valid", out_valid, 1);
      chk("rr_id", out_id, i % 2);
      chk("rr_res", out_res, (i % 2 == 0) ? 32'd2 : 32'd5);
    end

    // Backpressure: the req1 result (5) must hold while both requesters wait.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {req1_ready, req0_ready}, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_id", out_id, 1);
      chk("bp_res", out_res, 5);
      chk("bp_cout", out_cout, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_ready", {req1_ready, req0_ready}, 1);
    tick();
    chk("drain_valid", out_valid, 1);
    chk("drain_id", out_id, 0);
    chk("drain_res", out_res, 2);

    // Reset while a result is held and both requests are pending.
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_res", out_res, 0);
    chk("post_rst_grant", {req1_ready, req0_ready}, 1);
    tick();
    chk("post_rst_id", out_id, 0);
    req1_valid = 1'b0;

    // Exhaustive sweep through requester 0.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          req0_valid = 1'b1;
          req0_a = a[3:0]; req0_b = b[3:0]; req0_sel = s[0];
          r = (s == 0) ? (a + b) : (a - b + 16);
          tick();
          chk("sweep_res", out_res, r % 16);
          chk("sweep_cout", out_cout, r / 16);
        end
      end
    end
    req0_valid = 1'b0;
    tick();
    chk("end_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
